shift_normalizer: RTL
=====================

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 The block SHALL have one parameter: W, default 8, operand width in bits; AW = $clog2(W) is derived, not a parameter.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled only while ready=1.
REQ-006 a  input  W  operand to normalize.
REQ-007 choice  input  1  0 = left-normalize until y[W-1]=1; 1 = right-normalize until y[0]=1.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done_tick  output  1  one-cycle pulse when a result is valid.
REQ-010 y  output  W  normalized operand.
REQ-011 amt  output  AW  number of single-bit shifts applied.
REQ-012 zero  output  1  operand was all-zero; present only when the macro in REQ-026 is defined.

Function
REQ-013 The block SHALL be the inverse of the left/right shifter: it recovers the shift amount by shifting iteratively, one bit per cycle, filling vacated bits with 0.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; no other states.
REQ-015 In IDLE with start=1, the block SHALL latch a into y and choice internally, clear amt, and go to SHIFT at the next edge.
REQ-016 In SHIFT, if the target bit (y[W-1] for choice=0, y[0] for choice=1) is 1, the block SHALL go to DONE; otherwise it SHALL shift y one position toward the target and increment amt.
REQ-017 In SHIFT, when amt = W-1 and the target bit is 0, the block SHALL go to DONE without shifting further; amt SHALL never wrap.
REQ-018 DONE SHALL last exactly one cycle, assert done_tick, and return to IDLE.
REQ-019 For an operand needing k shifts, done_tick SHALL be high in the clock cycle beginning k+2 edges after the edge that sampled start.
REQ-020 start while ready=0 SHALL be ignored; a, choice changes during SHIFT/DONE SHALL not affect the result.
REQ-021 y and amt SHALL hold their final values from DONE until the next accepted start.
REQ-022 Round-trip: for a nonzero operand, shifting y by amt in the opposite direction SHALL reproduce a.

Reset
REQ-023 On reset, state SHALL be IDLE, ready=1, done_tick=0, y=0, amt=0, zero=0.
REQ-024 Reset asserted in SHIFT or DONE SHALL abort the operation; no done_tick is produced for it.
REQ-025 Reset and start in the same cycle: reset SHALL win; start is dropped.

Configuration
REQ-026 Macro SHIFT_NORM_ZERO_DETECT_EN: when defined, an all-zero operand SHALL go IDLE->DONE directly (done_tick 1 edge after start) with zero=1, amt=0, y=0; zero SHALL be cleared on the next accepted start.
REQ-027 Without SHIFT_NORM_ZERO_DETECT_EN, the zero port SHALL not exist, and an all-zero operand SHALL iterate per REQ-017, ending with amt=W-1, y=0, done_tick W+1 edges after start.

Verification (W=8)
REQ-028 a=00010110, choice=0, start -> y=10110000, amt=3, done_tick 5 edges after start, single pulse.
REQ-029 a=11110000, choice=1 -> y=00001111, amt=4; a=10000000, choice=0 -> amt=0, y=10000000, done_tick 2 edges after start.
REQ-030 a=00000000 -> with macro: zero=1, amt=0, done_tick 1 edge after start; without: amt=7, y=0, done_tick 9 edges after start.
REQ-031 a=00000001, choice=0; second start with a=11111111 pulsed during SHIFT -> second start ignored, result amt=7, y=10000000.
REQ-032 Reset pulsed during SHIFT of a=00000100 -> next cycle IDLE, ready=1, y=0, amt=0, no done_tick; new start then completes normally.
REQ-033 Sweep all 256 operands x both choice values, feed y, amt, opposite choice to the existing combinational shifter -> output equals a for every nonzero a.

Source files
------------

// File: rtl/shift_normalizer.sv
// Iterative shift normalizer: shifts an operand one bit per cycle toward the chosen end until that
// bit is 1 and reports the number of shifts. Optional macro SHIFT_NORM_ZERO_DETECT_EN adds the zero port.
module shift_normalizer #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         a,
  input  logic                 choice,
  output logic                 ready,
  output logic                 done_tick,
  output logic [W-1:0]         y,
`ifdef SHIFT_NORM_ZERO_DETECT_EN
  output logic [$clog2(W)-1:0] amt,
  output logic                 zero
`else
  output logic [$clog2(W)-1:0] amt
`endif
);

  localparam int AW = $clog2(W);
  localparam logic [AW-1:0] AMT_MAX = AW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t          state_r, state_next_s;
  logic [W-1:0]    y_r, y_next_s;
  logic [AW-1:0]   amt_r, amt_next_s;
  logic            choice_r, choice_next_s;
  logic            ready_r, done_r;
  logic            target_s;
`ifdef SHIFT_NORM_ZERO_DETECT_EN
  logic            zero_r, zero_next_s;
`endif

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next_s  = state_r;
    y_next_s      = y_r;
    amt_next_s    = amt_r;
    choice_next_s = choice_r;
`ifdef SHIFT_NORM_ZERO_DETECT_EN
    zero_next_s   = zero_r;
`endif
    target_s      = choice_r ? y_r[0] : y_r[W-1];
    case (state_r)
      IDLE: begin
        if (start) begin
          y_next_s      = a;
          amt_next_s    = {AW{1'b0}};
          choice_next_s = choice;
          state_next_s  = SHIFT;
`ifdef SHIFT_NORM_ZERO_DETECT_EN
          zero_next_s   = (a == {W{1'b0}});
          if (a == {W{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = SHIFT;
          end
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (target_s) begin
          state_next_s = DONE;
        end else if (amt_r == AMT_MAX) begin
          // all-zero operand: stop at the last legal count rather than wrapping
          state_next_s = DONE;
        end else begin
          y_next_s   = choice_r ? {1'b0, y_r[W-1:1]} : {y_r[W-2:0], 1'b0};
          amt_next_s = amt_r + AW'(1'b1);
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers; done pulses the cycle after DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r      <= {W{1'b0}};
      amt_r    <= {AW{1'b0}};
      choice_r <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
`ifdef SHIFT_NORM_ZERO_DETECT_EN
      zero_r   <= 1'b0;
`endif
    end else begin
      y_r      <= y_next_s;
      amt_r    <= amt_next_s;
      choice_r <= choice_next_s;
      ready_r  <= (state_next_s == IDLE);
      done_r   <= (state_r == DONE);
`ifdef SHIFT_NORM_ZERO_DETECT_EN
      zero_r   <= zero_next_s;
`endif
    end
  end

  assign ready     = ready_r;
  assign done_tick = done_r;
  assign y         = y_r;
  assign amt       = amt_r;
`ifdef SHIFT_NORM_ZERO_DETECT_EN
  assign zero      = zero_r;
`endif

endmodule
